// File: rtl/frame_update_sched.sv
// frame_update_sched
// ------------------
// Per-frame scheduler for the 1024x768@60 raster (65 MHz pixel clock).
// At the start of vertical blanking it raises an update request for the
// game logic once every FRAME_DIV frames. The request is held until it is
// acknowledged. If it is still pending on the last cycle before pixel (0,0),
// it is dropped and flagged as an overrun.
//
// Optional feature: define FRAME_SCHED_OVERRUN_CNT_EN to build the 8-bit
// saturating overrun counter. When the macro is not defined, overrun_cnt
// is tied to zero.
//
// Ports:
//   clk          pixel clock
//   rst          synchronous, active-high reset
//   hcount       horizontal raster position
//   vcount       vertical raster position
//   pause        suppresses new requests (div_cnt holds)
//   upd_ack      single-cycle acknowledge from the game logic
//   upd_req      level request to the game logic
//   frame_tick   one-cycle pulse per frame (cycle after frame start)
//   frame_cnt    free-running 16-bit frame counter
//   overrun      one-cycle pulse when a request misses the deadline
//   overrun_cnt  saturating overrun count (0 unless the feature is enabled)
module frame_update_sched #(
  parameter int HOR_TOTAL_TIME  = 1344,
  parameter int VER_TOTAL_TIME  = 806,
  parameter int VER_BLANK_START = 768,
  parameter int FRAME_DIV       = 1,
  parameter int CNT_W           = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] hcount,
  input  logic [CNT_W-1:0] vcount,
  input  logic             pause,
  input  logic             upd_ack,
  output logic             upd_req,
  output logic             frame_tick,
  output logic [15:0]      frame_cnt,
  output logic             overrun,
  output logic [7:0]       overrun_cnt
);

  localparam logic [CNT_W-1:0] H_FIRST  = CNT_W'(0);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(HOR_TOTAL_TIME - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(VER_TOTAL_TIME - 1);
  localparam logic [CNT_W-1:0] V_BLANK  = CNT_W'(VER_BLANK_START);
  localparam logic [7:0]       DIV_LAST = 8'(FRAME_DIV - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  state_t      state_r;
  logic        upd_req_r;
  logic        frame_tick_r;
  logic [15:0] frame_cnt_r;
  logic        overrun_r;
  logic [7:0]  div_cnt_r;

  logic        fs_s;
  logic        dl_s;
  logic        due_s;
  logic        ovr_evt_s;

  // Exact-match decode: out-of-range raster values never hit either point.
  assign fs_s      = (hcount == H_FIRST) && (vcount == V_BLANK);
  assign dl_s      = (hcount == H_LAST)  && (vcount == V_LAST);
  assign due_s     = fs_s && !pause && (div_cnt_r == DIV_LAST);
  // The ack takes priority over the deadline in the same cycle.
  assign ovr_evt_s = (state_r == REQ) && dl_s && !upd_ack;

  // Frame bookkeeping and request divider.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_tick_r <= 1'b0;
      frame_cnt_r  <= 16'd0;
      div_cnt_r    <= 8'd0;
    end else begin
      frame_tick_r <= fs_s;
      if (fs_s) begin
        frame_cnt_r <= frame_cnt_r + 16'd1;
      end
      // The divider freezes while paused, so a paused due frame defers its
      // request to the next unpaused frame start.
      if (fs_s && !pause) begin
        if (div_cnt_r == DIV_LAST) begin
          div_cnt_r <= 8'd0;
        end else begin
          div_cnt_r <= div_cnt_r + 8'd1;
        end
      end
    end
  end

  // Request state machine with registered request and overrun pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      upd_req_r <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      overrun_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (due_s) begin
            state_r   <= REQ;
            upd_req_r <= 1'b1;
          end
        end
        REQ: begin
          // Pause is deliberately ignored here: an issued request stands.
          if (upd_ack) begin
            state_r   <= IDLE;
            upd_req_r <= 1'b0;
          end else if (dl_s) begin
            state_r   <= IDLE;
            upd_req_r <= 1'b0;
            overrun_r <= 1'b1;
          end
        end
        default: begin
          state_r   <= IDLE;
          upd_req_r <= 1'b0;
        end
      endcase
    end
  end

`ifdef FRAME_SCHED_OVERRUN_CNT_EN
  logic [7:0] overrun_cnt_r;

  // Saturating overrun counter, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_cnt_r <= 8'd0;
    end else if (ovr_evt_s && (overrun_cnt_r != 8'hFF)) begin
      overrun_cnt_r <= overrun_cnt_r + 8'd1;
    end
  end

  assign overrun_cnt = overrun_cnt_r;
`else
  assign overrun_cnt = 8'd0;
`endif

  assign upd_req    = upd_req_r;
  assign frame_tick = frame_tick_r;
  assign frame_cnt  = frame_cnt_r;
  assign overrun    = overrun_r;

endmodule

// File: doc/frame_update_sched.md
Name: frame_update_sched

Overview:
- Per-frame scheduler that sequences game-logic updates against the 1024x768@60 VGA raster running on the 65 MHz pixel clock.
- Watches the raster counters from the timing generator and issues one update request per N frames at the start of vertical blanking.
- Holds the request until the game logic acknowledges it, and flags an overrun if the request is still outstanding when active video is about to resume.
- Sits between the VGA timing generator and the game-state/physics logic.

Parameters:
- HOR_TOTAL_TIME, 1344, pixels per line including blanking.
- VER_TOTAL_TIME, 806, lines per frame including blanking.
- VER_BLANK_START, 768, first vertical blanking line.
- FRAME_DIV, 1, an update is requested every FRAME_DIV frames; range 1..255.
- CNT_W, 11, width of hcount and vcount.

Ports:
- clk  in  1  65 MHz pixel clock.
- rst  in  1  synchronous, active-high reset.
- hcount  in  CNT_W  horizontal raster position, 0..HOR_TOTAL_TIME-1.
- vcount  in  CNT_W  vertical raster position, 0..VER_TOTAL_TIME-1.
- pause  in  1  when high, suppresses new update requests.
- upd_ack  in  1  single-cycle acknowledge from the game logic.
- upd_req  out  1  update request, level signal.
- frame_tick  out  1  one-cycle pulse per frame.
- frame_cnt  out  16  free-running frame counter.
- overrun  out  1  one-cycle pulse when a request misses its deadline.
- overrun_cnt  out  8  saturating count of overruns.

Behaviour:
- All outputs are registered. Every output resets to 0, and so do div_cnt and the state register. The state after reset is IDLE.
- Frame start (fs): the cycle where hcount==0 and vcount==VER_BLANK_START.
- Deadline (dl): the cycle where hcount==HOR_TOTAL_TIME-1 and vcount==VER_TOTAL_TIME-1, i.e. the last cycle before pixel (0,0).
- Frame bookkeeping, on the cycle after fs:
  - frame_tick=1 for exactly one cycle.
  - frame_cnt increments; it wraps 0xFFFF -> 0.
- Divider: div_cnt counts frame starts from 0 to FRAME_DIV-1, then wraps.
  - A request is due at an fs where div_cnt==FRAME_DIV-1 and pause==0.
  - While pause==1, div_cnt holds its value; frame_cnt and frame_tick are unaffected.
- State machine, states IDLE and REQ:
  - IDLE -> REQ on a due fs. upd_req goes high on the next cycle, so latency is 1 cycle from fs.
  - REQ -> IDLE when upd_ack==1. upd_req goes low on the cycle after the ack.
  - REQ -> IDLE on dl with upd_ack==0. The request is aborted: upd_req goes low on the next cycle, overrun pulses for one cycle, and overrun_cnt increments, saturating at 255.
  - If dl and upd_ack occur in the same cycle, the ack wins: no overrun.
  - upd_ack received in IDLE is ignored.
  - pause rising while in REQ does not withdraw the outstanding request.
- Counters are compared with ==. Counter values outside the stated ranges never match fs or dl and cause no action.
- Reset mid-request: on the cycle after rst, upd_req=0, state=IDLE, div_cnt=0. A pending ack is lost and is not counted as an overrun.
- With FRAME_DIV==1, every unpaused frame issues a request.

Optional Feature:
- Macro FRAME_SCHED_OVERRUN_CNT_EN.
- Defined: overrun_cnt is implemented as specified, 8-bit saturating, cleared only by rst.
- Undefined: no counter register is built and overrun_cnt is tied to 0. The overrun pulse is unaffected.

Test Plan:
- Reset, then drive the raster from (0,0) to fs (h=0, v=768) -> frame_tick=1 and upd_req=1 on the next cycle; frame_cnt=1.
- Assert upd_ack 10 cycles after upd_req rises -> upd_req=0 on the cycle after the ack; no overrun; overrun_cnt stays 0.
- Never ack -> at h=1343, v=805 the next cycle shows overrun=1 for one cycle, upd_req=0, overrun_cnt=1. Repeat for 300 frames -> overrun_cnt=255, held there (0 with the macro undefined).
- FRAME_DIV=3, pause=0 -> upd_req rises only on frames 3, 6 and 9 of 9; with pause=1 during frame 3, the request is deferred to frame 4.
- upd_ack coincident with dl -> no overrun pulse; upd_req=0 on the next cycle.
- Assert rst for 1 cycle while upd_req=1 -> all outputs 0 on the next cycle; the next fs produces upd_req exactly as after power-up.
